sfp_acc_ctrl: RTL and testbench
===============================

# sfp_acc_ctrl

Sequencer that drives the special-function (accumulate + ReLU) stage from the psum memory side. For each output pixel it reads the `kij` partial sums stored for that pixel, streams them into the SFP column with `acc` strobes, and writes the post-ReLU result to the output memory. It also clears the SFP between pixels. It sits between the psum SRAM written by the array/OFIFO path and the SFP column, one instance per SFP column.

## Interface
- `psum_bw`, 16, psum/data width
- `kij`, 9, partial sums per output pixel (kernel positions)
- `num_out`, 16, output pixels per run
- `psum_aw`, `$clog2(kij*num_out)`, psum memory address width
- `out_aw`, `$clog2(num_out)`, output memory address width

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset)
- `start`  in  1  begin a run; sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted through the WRITE of the last pixel
- `done`  out  1  one-cycle pulse after the last write
- `psum_ren`  out  1  psum memory read enable
- `psum_addr`  out  psum_aw  psum read address
- `psum_rdata`  in  psum_bw  signed read data, valid the cycle after `psum_ren`
- `sfp_acc`  out  1  accumulate strobe to SFP
- `sfp_clr`  out  1  synchronous clear to SFP
- `sfp_data_in`  out  psum_bw  signed; combinational copy of `psum_rdata`
- `sfp_data_out`  in  psum_bw  signed accumulated/ReLU value from SFP
- `out_wen`  out  1  output memory write enable
- `out_addr`  out  out_aw  output pixel index
- `out_wdata`  out  psum_bw  combinational copy of `sfp_data_out`

## Operation
- Psum layout is kij-major: the psum for pixel `o` at kernel position `k` is at address `k*num_out + o`. Address generation uses a running base register (add `num_out` per read) and no multiplier.
- FSM states:
  - IDLE: `start` → CLR, with pixel counter `o`=0.
  - CLR: lasts 1 cycle with `sfp_clr`=1. Then → READ.
  - READ: lasts exactly `kij` cycles. `psum_ren`=1 and `psum_addr`=`k*num_out+o` for `k`=0..`kij`-1. Then → DRAIN.
  - DRAIN: lasts 1 cycle; no read. Then → WRITE.
  - WRITE: lasts 1 cycle with `out_wen`=1, `out_addr`=`o`, `out_wdata`=`sfp_data_out`, and `sfp_clr`=1 in the same cycle (the clear lands at the closing edge). If `o`=`num_out`-1 → DONE, else `o`++ → READ.
  - DONE: `done`=1 for 1 cycle. Then → IDLE.
- `sfp_acc` is `psum_ren` delayed one cycle, so `sfp_acc` is high during READ cycles 2..`kij` and the DRAIN cycle. That is exactly `kij` strobes per pixel, matching the SFP's kij-count ReLU point.
- `start` is ignored outside IDLE.
- Pixel result is `max(0, Σ psums)` as computed by the SFP, including its wrap behaviour. This block performs no arithmetic on data.
- Reset (`reset`=0, at any time, including mid-run):
  - FSM → IDLE, all counters 0.
  - `busy`, `done`, `psum_ren`, `sfp_acc`, `sfp_clr`, `out_wen` = 0; `psum_addr`, `out_addr` = 0.
  - A partially processed pixel is abandoned. The next run starts with CLR, so stale SFP state is discarded.

## Timing
- Cycle 0 = the edge where `start`=1 is sampled in IDLE.
- CLR is at cycle 1. Pixel `o` is READ during cycles `2+o*(kij+2)` .. `1+o*(kij+2)+kij`.
- Write of pixel `o` is at cycle `1+(o+1)*(kij+2)`. With defaults, pixel 0 is written at cycle 12 and pixel 15 at cycle 177.
- `done` is at cycle `2+num_out*(kij+2)`, which is 178 with defaults. `start` may be re-accepted the cycle after `done`.
- Throughput is `kij+2` cycles per pixel. Read latency of the psum memory is fixed at 1 cycle; no back-pressure exists.

## Test plan
- All 144 psums = 1 (defaults, behavioural SFP) → 16 writes, each `out_wdata`=9. Writes at cycles 12, 23, …, 177; `done` at 178.
- All psums = -1 → every `out_wdata`=0 (ReLU). Exactly 9 `sfp_acc` strobes between consecutive `sfp_clr` pulses.
- Pixel 3 has `k`=0..7 = +10 and `k`=8 = -100 → out[3]=0. Pixel 4 has `k`=8 = +5 → out[4]=85. Pixel 4's read addresses are 4, 20, 36, …, 132.
- `start` pulsed again at cycles 5 and 100 → ignored. Exactly 16 writes and one `done`.
- `reset`=0 asynchronously at cycle 50 → all outputs 0 immediately and no further writes. After release plus `start`, a full correct run completes with the same timing as above.
- `kij`=4, `num_out`=3, psums = address value → out[o] = `4*o+18`. `done` at cycle 20.

Source files
------------

// File: rtl/sfp_acc_ctrl.sv
// Sequencer feeding one SFP column: reads the kij partial sums of each output
// pixel from psum memory, strobes them into the SFP, and writes the ReLU result out.
module sfp_acc_ctrl #(
  parameter int psum_bw = 16,
  parameter int kij     = 9,
  parameter int num_out = 16,
  parameter int psum_aw = $clog2(kij*num_out),
  parameter int out_aw  = $clog2(num_out)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      psum_ren,
  output logic [psum_aw-1:0]        psum_addr,
  input  logic signed [psum_bw-1:0] psum_rdata,
  output logic                      sfp_acc,
  output logic                      sfp_clr,
  output logic signed [psum_bw-1:0] sfp_data_in,
  input  logic signed [psum_bw-1:0] sfp_data_out,
  output logic                      out_wen,
  output logic [out_aw-1:0]         out_addr,
  output logic signed [psum_bw-1:0] out_wdata
);

  localparam int K_W = (kij > 1) ? $clog2(kij) : 1;
  localparam logic [K_W-1:0]     K_LAST = K_W'(kij - 1);
  localparam logic [K_W-1:0]     K_ONE  = K_W'(1);
  localparam logic [out_aw-1:0]  O_LAST = out_aw'(num_out - 1);
  localparam logic [out_aw-1:0]  O_ONE  = out_aw'(1);
  localparam logic [psum_aw-1:0] STRIDE = psum_aw'(num_out);
  localparam logic [psum_aw-1:0] A_ONE  = psum_aw'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [out_aw-1:0]   pix;
  logic [K_W-1:0]      k;
  logic [psum_aw-1:0]  addr;
  logic                vld_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      pix    <= '0;
      k      <= '0;
      addr   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= psum_ren;
      case (state)
        S_IDLE: begin
          if (start) begin
            pix  <= '0;
            k    <= '0;
            addr <= '0;
          end
        end
        S_READ: begin
          // Running base walks the kij-major layout without a multiplier.
          if (k == K_LAST) begin
            k <= '0;
          end else begin
            k    <= k + K_ONE;
            addr <= addr + STRIDE;
          end
        end
        S_WRITE: begin
          if (pix != O_LAST) begin
            pix  <= pix + O_ONE;
            addr <= psum_aw'(pix) + A_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    psum_ren  = 1'b0;
    sfp_clr   = 1'b0;
    out_wen   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLR;
      end
      S_CLR: begin
        busy      = 1'b1;
        sfp_clr   = 1'b1;
        state_nxt = S_READ;
      end
      S_READ: begin
        busy     = 1'b1;
        psum_ren = 1'b1;
        if (k == K_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy      = 1'b1;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        // Clear rides along with the write so the next pixel starts from zero.
        busy      = 1'b1;
        out_wen   = 1'b1;
        sfp_clr   = 1'b1;
        state_nxt = (pix == O_LAST) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p1: read data returns one cycle after the read, tagged by vld_p1.
  assign sfp_acc     = vld_p1;
  assign sfp_data_in = psum_rdata;
  assign psum_addr   = addr;
  assign out_addr    = pix;
  assign out_wdata   = sfp_data_out;

endmodule

// File: tb/tb_sfp_acc_ctrl.sv
// Randomized bench for sfp_acc_ctrl: behavioural psum memory and SFP around the
// DUT, with a cycle-indexed reference model checked every cycle.
module tb_sfp_acc_ctrl;

  localparam int K = 9;
  localparam int N = 16;
  localparam int P = K + 2;
  localparam int LAST_C = 2 + N*P;

  logic clk, reset, start;
  logic busy, done, psum_ren, sfp_acc, sfp_clr, out_wen;
  logic [7:0] psum_addr;
  logic [3:0] out_addr;
  logic signed [15:0] psum_rdata, sfp_data_in, sfp_data_out, out_wdata;

  int n_chk = 0;
  int n_err = 0;

  sfp_acc_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .psum_ren(psum_ren), .psum_addr(psum_addr), .psum_rdata(psum_rdata),
    .sfp_acc(sfp_acc), .sfp_clr(sfp_clr), .sfp_data_in(sfp_data_in),
    .sfp_data_out(sfp_data_out), .out_wen(out_wen), .out_addr(out_addr),
    .out_wdata(out_wdata)
  );

  // Second instance with a small geometry.
  logic start2, busy2, done2, psum_ren2, sfp_acc2, sfp_clr2, out_wen2;
  logic [3:0] psum_addr2;
  logic [1:0] out_addr2;
  logic signed [15:0] psum_rdata2, sfp_data_in2, sfp_data_out2, out_wdata2;

  sfp_acc_ctrl #(.kij(4), .num_out(3)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .psum_ren(psum_ren2), .psum_addr(psum_addr2), .psum_rdata(psum_rdata2),
    .sfp_acc(sfp_acc2), .sfp_clr(sfp_clr2), .sfp_data_in(sfp_data_in2),
    .sfp_data_out(sfp_data_out2), .out_wen(out_wen2), .out_addr(out_addr2),
    .out_wdata(out_wdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment: psum memory with 1-cycle read latency, behavioural SFP.
  logic signed [15:0] mem [K*N];
  logic signed [15:0] sacc, sacc2;

  always @(posedge clk) if (psum_ren) psum_rdata <= mem[psum_addr];
  always @(posedge clk) begin
    if (sfp_clr) sacc <= 16'sd0;
    else if (sfp_acc) sacc <= sacc + sfp_data_in;
  end
  assign sfp_data_out = (sacc < 0) ? 16'sd0 : sacc;

  always @(posedge clk) if (psum_ren2) psum_rdata2 <= {12'd0, psum_addr2};
  always @(posedge clk) begin
    if (sfp_clr2) sacc2 <= 16'sd0;
    else if (sfp_acc2) sacc2 <= sacc2 + sfp_data_in2;
  end
  assign sfp_data_out2 = (sacc2 < 0) ? 16'sd0 : sacc2;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: position within a run, 1 = clear cycle, 0 = idle.
  int run_c;
  always @(posedge clk or negedge reset) begin
    if (!reset) run_c <= 0;
    else if (run_c == 0) run_c <= start ? 1 : 0;
    else if (run_c == LAST_C) run_c <= 0;
    else run_c <= run_c + 1;
  end

  function automatic bit m_busy(int c); return c >= 1 && c <= LAST_C - 1; endfunction
  function automatic bit m_ren(int c);
    return c >= 2 && c <= LAST_C - 1 && ((c - 2) % P) < K;
  endfunction
  function automatic bit m_wen(int c);
    return c >= 2 && c <= LAST_C - 1 && ((c - 2) % P) == K + 1;
  endfunction
  function automatic int m_pix(int c); return (c - 2) / P; endfunction
  function automatic int m_addr(int c); return ((c - 2) % P) * N + (c - 2) / P; endfunction
  function automatic logic signed [15:0] exp_pix(int o);
    logic signed [15:0] s;
    s = 16'sd0;
    for (int kk = 0; kk < K; kk++) s += mem[kk*N + o];
    return (s < 0) ? 16'sd0 : s;
  endfunction

  int wr_cnt, done_cnt, first_wr, last_wr, done_c, a46, a54, cc;
  logic signed [15:0] outlog [N];

  always @(negedge clk) begin
    cc = run_c;
    if (!reset) begin
      chk("rst_ctrl", {busy, done, psum_ren, sfp_acc, sfp_clr, out_wen}, 0);
      chk("rst_psum_addr", psum_addr, 0);
      chk("rst_out_addr", out_addr, 0);
    end else begin
      if (cc == 1) begin wr_cnt = 0; done_cnt = 0; end
      chk("busy", busy, m_busy(cc));
      chk("done", done, cc == LAST_C);
      chk("psum_ren", psum_ren, m_ren(cc));
      if (m_ren(cc)) chk("psum_addr", psum_addr, m_addr(cc));
      chk("sfp_acc", sfp_acc, cc >= 1 && m_ren(cc - 1));
      chk("sfp_clr", sfp_clr, cc == 1 || m_wen(cc));
      chk("out_wen", out_wen, m_wen(cc));
      if (m_wen(cc)) begin
        chk("out_addr", out_addr, m_pix(cc));
        chk("out_wdata", out_wdata, exp_pix(m_pix(cc)));
      end
      chk("sfp_data_in_copy", sfp_data_in, psum_rdata);
      chk("out_wdata_copy", out_wdata, sfp_data_out);
      if (cc == 46) a46 = psum_addr;
      if (cc == 54) a54 = psum_addr;
    end
    if (out_wen) begin
      if (wr_cnt == 0) first_wr = cc;
      last_wr = cc;
      outlog[out_addr] = out_wdata;
      wr_cnt++;
    end
    if (done) begin done_cnt++; done_c = cc; end
  end

  task automatic do_run(input int x1, input int x2, input int rst_at);
    int i;
    int w;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    i = 0;
    while (run_c != 0 && i < 600) begin
      start = (run_c == x1 || run_c == x2);
      if (run_c == rst_at) begin
        #2 reset = 1'b0;
        #1;
        chk("rst_imm_ctrl", {busy, done, psum_ren, sfp_acc, sfp_clr, out_wen}, 0);
        chk("rst_imm_psum_addr", psum_addr, 0);
        chk("rst_imm_out_addr", out_addr, 0);
      end
      @(negedge clk);
      i++;
    end
    start = 1'b0;
    chk("run_timeout", i < 600, 1);
    if (rst_at >= 0) begin
      w = wr_cnt;
      chk("writes_before_rst", w, 4);
      repeat (4) @(negedge clk);
      chk("no_wr_after_rst", wr_cnt, w);
      #2 reset = 1'b1;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  int wr2, done2_c;
  logic signed [15:0] out2 [3];

  initial begin
    reset = 1'b0; start = 1'b0; start2 = 1'b0;
    for (int i = 0; i < K*N; i++) mem[i] = 16'sd0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);

    // All psums = 1.
    for (int i = 0; i < K*N; i++) mem[i] = 16'sd1;
    do_run(-1, -1, -1);
    chk("t1_writes", wr_cnt, 16);
    chk("t1_first_wr_cycle", first_wr, 12);
    chk("t1_last_wr_cycle", last_wr, 177);
    chk("t1_done_cycle", done_c, 178);
    chk("t1_out0", outlog[0], 9);
    chk("t1_out15", outlog[15], 9);

    // All psums = -1: ReLU clamps every pixel.
    for (int i = 0; i < K*N; i++) mem[i] = -16'sd1;
    do_run(-1, -1, -1);
    chk("t2_writes", wr_cnt, 16);
    chk("t2_out7", outlog[7], 0);

    // Random small psums with pixels 3 and 4 pinned.
    for (int i = 0; i < K*N; i++) mem[i] = 16'(int'($urandom_range(0, 200)) - 100);
    for (int kk = 0; kk < 8; kk++) begin
      mem[kk*N + 3] = 16'sd10;
      mem[kk*N + 4] = 16'sd10;
    end
    mem[8*N + 3] = -16'sd100;
    mem[8*N + 4] = 16'sd5;
    do_run(-1, -1, -1);
    chk("t3_out3", outlog[3], 0);
    chk("t3_out4", outlog[4], 85);
    chk("t3_pix4_addr_k0", a46, 4);
    chk("t3_pix4_addr_k8", a54, 132);

    // Full-range random psums (wrap) with stray start pulses.
    for (int i = 0; i < K*N; i++) mem[i] = 16'($urandom);
    do_run(5, 100, -1);
    chk("t4_writes", wr_cnt, 16);
    chk("t4_done_count", done_cnt, 1);

    // Reset mid-run, then a clean run.
    for (int i = 0; i < K*N; i++) mem[i] = 16'(int'($urandom_range(0, 2000)) - 1000);
    do_run(-1, -1, 50);
    do_run(-1, -1, -1);
    chk("t5_writes", wr_cnt, 16);
    chk("t5_done_cycle", done_c, 178);
    chk("t5_done_count", done_cnt, 1);

    // Small geometry: kij=4, num_out=3, psum = address.
    wr2 = 0; done2_c = -1;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (out_wen2) begin out2[out_addr2] = out_wdata2; wr2++; end
      if (done2) begin done2_c = i; break; end
    end
    chk("t6_done_cycle", done2_c, 20);
    chk("t6_writes", wr2, 3);
    chk("t6_out0", out2[0], 18);
    chk("t6_out1", out2[1], 22);
    chk("t6_out2", out2[2], 26);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
